// File: rtl/cmp_share_arb.sv
// Round-robin arbiter that shares one 32-bit signed/unsigned less-than datapath
// among NREQ requesters, with a single-entry registered response buffer.
module cmp_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] ptr_next;
  logic           any_valid;
  logic           can_accept;
  logic           accept;
  logic [3:0]     sel_op;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic           cmp_result;
  logic           cmp_err;

  assign can_accept = (state == EMPTY) || rsp_ready;
  assign rsp_valid  = (state == FULL);

  // Descending scan so the entry closest to ptr is written last and wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt       = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        req_ready[i] = rst_n && any_valid && can_accept;
        sel_op       = req_op[i*4 +: 4];
        sel_a        = req_a[i*32 +: 32];
        sel_b        = req_b[i*32 +: 32];
      end
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign ptr_next = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    cmp_result = 1'b0;
    cmp_err    = 1'b0;
    case (sel_op)
      OP_SLT:  cmp_result = $signed(sel_a) < $signed(sel_b);
      OP_SLTU: cmp_result = sel_a < sel_b;
      default: cmp_err    = 1'b1;
    endcase
  end

  // An accept overwrites the buffer even while draining, giving one response per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      state      <= FULL;
      ptr        <= ptr_next;
      rsp_id     <= gnt;
      rsp_result <= {31'd0, cmp_result};
      rsp_err    <= cmp_err;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed testbench for cmp_share_arb with two requesters; expected values are
// hand-computed constants checked through immediate assertions.
module tb_cmp_share_arb;

  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*4-1:0]    req_op;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_result;
  logic                 rsp_err;

  int total_checks;
  int passed_checks;

  cmp_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic apply_stimulus(input int idx, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    req_op[idx*4 +: 4]  = op;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic vld, input logic [IDW-1:0] id,
                           input logic [31:0] res, input logic err);
    check_output({tag, "_valid"},  {31'd0, rsp_valid}, {31'd0, vld});
    check_output({tag, "_id"},     {30'd0, rsp_id},    {30'd0, id});
    check_output({tag, "_result"}, rsp_result,         res);
    check_output({tag, "_err"},    {31'd0, rsp_err},   {31'd0, err});
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests pending so ready must stay low.
    #2;
    req_valid = 2'b11;
    #1;
    check_rsp("reset", 1'b0, 2'd0, 32'd0, 1'b0);
    check_output("reset_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    #9;
    rst_n = 1'b1;

    // Requester 0 signed: -1 < 1.
    apply_stimulus(0, 4'b1000, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 2'b01;
    #1;
    check_output("t1_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check_rsp("t1", 1'b1, 2'd0, 32'd1, 1'b0);

    // Requester 1 unsigned with the same operands.
    apply_stimulus(1, 4'b1001, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 2'b10;
    #1;
    check_output("t2_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    check_rsp("t2", 1'b1, 2'd1, 32'd0, 1'b0);

    // Boundary 0x80000000 vs 0x7FFFFFFF.
    apply_stimulus(0, 4'b1000, 32'h8000_0000, 32'h7FFF_FFFF);
    req_valid = 2'b01;
    step();
    check_rsp("t3s", 1'b1, 2'd0, 32'd1, 1'b0);
    apply_stimulus(1, 4'b1001, 32'h8000_0000, 32'h7FFF_FFFF);
    req_valid = 2'b10;
    step();
    check_rsp("t3u", 1'b1, 2'd1, 32'd0, 1'b0);

    // Drain without refill keeps the data fields.
    req_valid = 2'b00;
    step();
    check_rsp("drain", 1'b0, 2'd1, 32'd0, 1'b0);

    // Both requesters valid: strict alternation with no bubbles.
    apply_stimulus(0, 4'b1000, 32'd1, 32'd2);
    apply_stimulus(1, 4'b1001, 32'd5, 32'd3);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      #1;
      check_output($sformatf("rr%0d_ready", n), {30'd0, req_ready},
                   (n % 2 == 0) ? 32'd1 : 32'd2);
      step();
      check_rsp($sformatf("rr%0d", n), 1'b1, IDW'(n % 2),
                (n % 2 == 0) ? 32'd1 : 32'd0, 1'b0);
    end

    // Backpressure for three cycles while FULL.
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      check_output($sformatf("bp%0d_ready", n), {30'd0, req_ready}, 32'd0);
      step();
      check_rsp($sformatf("bp%0d", n), 1'b1, 2'd1, 32'd0, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    check_output("bp_release_ready", {30'd0, req_ready}, 32'd1);
    step();
    check_rsp("bp_release", 1'b1, 2'd0, 32'd1, 1'b0);
    req_valid = 2'b00;
    step();
    check_output("bp_drain_valid", {31'd0, rsp_valid}, 32'd0);

    // Illegal op: handshake completes, error flagged, pointer wraps past idle requester 1.
    apply_stimulus(0, 4'b0000, 32'd1, 32'd5);
    req_valid = 2'b01;
    #1;
    check_output("err_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check_rsp("err", 1'b1, 2'd0, 32'd0, 1'b1);

    // Equal operands under the unsigned op give 0.
    apply_stimulus(1, 4'b1001, 32'd7, 32'd7);
    req_valid = 2'b10;
    step();
    check_rsp("equ", 1'b1, 2'd1, 32'd0, 1'b0);
    apply_stimulus(0, 4'b1000, 32'd7, 32'd7);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check_rsp("eqs", 1'b1, 2'd0, 32'd0, 1'b0);

    // Asynchronous reset mid-cycle with a pending response and ptr at 1.
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
    #3;
    rst_n = 1'b1;
    apply_stimulus(0, 4'b1000, 32'd0, 32'd1);
    apply_stimulus(1, 4'b1001, 32'd3, 32'd2);
    req_valid = 2'b11;
    #1;
    check_output("post_rst_ready0", {30'd0, req_ready}, 32'd1);
    step();
    check_rsp("post_rst0", 1'b1, 2'd0, 32'd1, 1'b0);
    #1;
    check_output("post_rst_ready1", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    check_rsp("post_rst1", 1'b1, 2'd1, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/cmp_share_arb.md
Name: cmp_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit signed/unsigned compare datapath among NREQ requesters, e.g. the ALU SLT/SLTU path and the branch-resolution path.
- Each requester uses a valid/ready handshake. Results return through a single registered response port that carries the requester ID and supports backpressure.
- Sits between the issue/execute requesters and the shared comparator.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of the requester ID field; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. The block uses one clock; reset is asynchronous and active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_op  input  NREQ*4  packed op codes; slot i is bits [4i+3:4i]. 4'b1000 = signed less-than, 4'b1001 = unsigned less-than.
- req_a  input  NREQ*32  packed operand A per requester.
- req_b  input  NREQ*32  packed operand B per requester.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts the response.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_result  output  32  compare result: 32'h1 or 32'h0.
- rsp_err  output  1  set when the op was not 4'b1000 or 4'b1001.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_result=0, rsp_id=0, rsp_err=0.
  - Priority pointer ptr=0.
  - req_ready is combinational and is forced to 0 while rst_n is low.
- Output buffer and FSM: a single-entry output buffer with two states.
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | rsp_ready.
- Arbitration (combinational):
  - Scan requesters starting at ptr, wrapping modulo NREQ.
  - gnt = first index with req_valid set.
  - req_ready[gnt] = can_accept. All other req_ready bits are 0.
  - If no req_valid bit is set, all req_ready bits are 0.
- Accept = req_valid[gnt] & req_ready[gnt]. On an accept edge:
  - Compute the result from slot gnt. For op 4'b1000, result = (signed a < signed b). For op 4'b1001, result = (unsigned a < unsigned b). Any other op gives result 0 and err=1.
  - Register rsp_result, rsp_id=gnt and rsp_err.
  - Set rsp_valid=1 (state FULL).
  - Update ptr = (gnt+1) mod NREQ.
- Without an accept, ptr holds its value.
- Drain without refill: rsp_valid & rsp_ready with no accept gives state EMPTY and rsp_valid=0 on the next edge. The rsp_* data fields keep their last value.
- Simultaneous drain and accept: the buffer is overwritten with the new result and rsp_valid stays 1. This gives one response per cycle of sustained throughput.
- Latency: a request accepted at edge N is presented as a response from edge N through the cycle after edge N, i.e. one cycle latency from request cycle to response cycle.
- Backpressure: while FULL and rsp_ready=0:
  - all req_ready bits are 0;
  - rsp_id, rsp_result and rsp_err are held stable.
- Requester obligations:
  - Hold req_op, req_a and req_b stable while req_valid is high until accepted.
  - Do not drop req_valid before it is accepted.
  - The arbiter does not rely on these rules for correctness, but verification checks them.
- ptr wrap: after granting index NREQ-1, ptr returns to 0.
- Fairness: any requester held valid is granted within NREQ accepts.
- Reset mid-operation: a pending response is discarded without a handshake and ptr returns to 0.
- Compare boundary values:
  - 0x80000000 vs 0x7FFFFFFF: signed result 1, unsigned result 0.
  - Equal operands give result 0 for both ops.

Test Plan:
- Reset, then requester 0 sends op 1000, a=0xFFFFFFFF, b=0x00000001 -> req_ready[0]=1; next cycle rsp_valid=1, rsp_id=0, rsp_result=1, rsp_err=0.
- Requester 1 sends op 1001 with the same operands -> rsp_id=1, rsp_result=0. Then a=0x80000000, b=0x7FFFFFFF under op 1000 gives 1 and under op 1001 gives 0.
- Both requesters valid continuously with rsp_ready=1 -> grants and rsp_id alternate 0,1,0,1 with one response every cycle, with no bubbles.
- rsp_ready=0 for 3 cycles while FULL and both requesters valid -> req_ready=00 and rsp_* fields stable. When rsp_ready rises, the next grant goes to the ptr requester.
- Op 4'b0000 from requester 0 with a=1, b=5 -> rsp_result=0, rsp_err=1, handshake completes normally.
- Assert rst_n low asynchronously while rsp_valid=1 -> rsp_valid=0 immediately and ptr=0. After release, a simultaneous request from both requesters grants requester 0 first.
